mod_addsub_seq: RTL and testbench

MOD_ADDSUB_SEQ -- requirements
Module: mod_addsub_seq

---
 rtl/mod_addsub_seq.sv | 167 ++++++++++++++++
 tb/tb_mod_addsub_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_seq.sv
// rtl/mod_addsub_seq.sv - sequential modular adder/subtractor built around one pipelined wide adder
//
// mpadder3: 1027-bit add/subtract, 1028-bit registered sum, one cycle latency.
//   clk      : rising-edge clock (pipeline register has no reset)
//   in_a     : minuend / addend
//   in_b     : subtrahend / addend
//   subtract : 0 = in_a + in_b, 1 = in_a - in_b (two's complement)
//   result   : registered sum
//
// mod_addsub_seq: computes (A+B) mod M or (A-B) mod M in a fixed 4-cycle sequence.
//   clk      : rising-edge clock
//   resetn   : asynchronous active-low reset
//   start    : request strobe, sampled only in IDLE
//   subtract : 0 = add, 1 = subtract
//   in_a     : operand A (A < M)
//   in_b     : operand B (B < M)
//   in_m     : modulus M (M > 0)
//   result   : registered modular result, valid while done is high
//   done     : one-cycle completion pulse
//   busy     : high in every non-IDLE state

module mpadder3 (
    input  logic          clk,
    input  logic [1026:0] in_a,
    input  logic [1026:0] in_b,
    input  logic          subtract,
    output logic [1027:0] result
);
    logic [1027:0] sum;

    // a - b is formed as a + ~b + 1
    always_comb begin
        sum = {1'b0, in_a} + {1'b0, in_b ^ {1027{subtract}}} + {1027'd0, subtract};
    end

    always_ff @(posedge clk) begin
        result <= sum;
    end
endmodule

module mod_addsub_seq #(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);
    localparam int W   = 1027;
    localparam int PAD = W - N;

    typedef enum logic [2:0] {
        IDLE,
        OP1,
        OP2,
        FIN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   m_q, m_d;
    logic           sub_q, sub_d;
    logic [W-1:0]   s_q, s_d;
    logic [N-1:0]   result_q, result_d;

    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_sub;
    logic [W:0]     add_sum;
    logic           unused_carry;

    mpadder3 u_adder (
        .clk      (clk),
        .in_a     (add_a),
        .in_b     (add_b),
        .subtract (add_sub),
        .result   (add_sum)
    );

    // Carry out of the wide adder carries no information: bit W-1 is the sign.
    assign unused_carry = add_sum[W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sub_q    <= 1'b0;
            s_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            sub_q    <= sub_d;
            s_q      <= s_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        sub_d    = sub_q;
        s_d      = s_q;
        result_d = result_q;
        add_a    = {{PAD{1'b0}}, a_q};
        add_b    = {{PAD{1'b0}}, b_q};
        add_sub  = sub_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    sub_d   = subtract;
                    state_d = OP1;
                end
            end
            OP1: begin
                state_d = OP2;
            end
            OP2: begin
                // S = A +/- B is only now emerging from the adder, so it is fed
                // straight back for the correction step while being captured.
                s_d     = add_sum[W-1:0];
                add_a   = add_sum[W-1:0];
                add_b   = {{PAD{1'b0}}, m_q};
                add_sub = ~sub_q;
                state_d = FIN;
            end
            FIN: begin
                // Add: keep S - M unless it went negative.
                // Subtract: use S + M only when S itself went negative.
                if (sub_q) begin
                    result_d = s_q[W-1] ? add_sum[N-1:0] : s_q[N-1:0];
                end else begin
                    result_d = add_sum[W-1] ? s_q[N-1:0] : add_sum[N-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_mod_addsub_seq.sv
// tb/tb_mod_addsub_seq.sv - self-checking bench for mod_addsub_seq
module tb_mod_addsub_seq;
    localparam int N = 1024;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         subtract;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;
    logic         busy;

    int           errors;
    int           checks;
    logic [N-1:0] prev_res;

    mod_addsub_seq #(.N(N)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_m     (in_m),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] rnd_wide();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: plain modular arithmetic on one-bit-wider values.
    function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m, input logic s);
        logic [N:0] ae, be, me, r;
        ae = {1'b0, a};
        be = {1'b0, b};
        me = {1'b0, m};
        if (!s) r = (ae + be) % me;
        else    r = (ae + me - be) % me;
        return r[N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h (low 192 bits shown)", tag, obs[191:0], exp[191:0]);
        end
    endtask

    // Starts one operation in the current cycle t (called right after a negedge)
    // and returns at the negedge of cycle t+5, when a new start may be issued.
    // noisy=1 keeps start high with scrambled operands during t+1..t+3.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                          input logic s, input logic [N-1:0] exp, input string tag,
                          input bit noisy);
        logic [4:0] dn;
        logic [4:0] bz;
        logic       hold_ok;
        logic [N-1:0] res_at_done;
        logic [N-1:0] res_after;
        hold_ok = 1'b1;
        res_at_done = '0;
        res_after = '0;
        in_a = a;
        in_b = b;
        in_m = m;
        subtract = s;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start    = noisy && (c < 4);
            in_a     = rnd_wide();
            in_b     = rnd_wide();
            in_m     = rnd_wide();
            subtract = 1'($urandom);
            dn[c-1] = done;
            bz[c-1] = busy;
            if (c < 4 && result !== prev_res) hold_ok = 1'b0;
            if (c == 4) res_at_done = result;
            if (c == 5) res_after = result;
        end
        start = 1'b0;
        chk({tag, "_done_timing"}, N'(dn), N'(5'b01000));
        chk({tag, "_busy"}, N'(bz), N'(5'b01111));
        chk({tag, "_hold"}, N'(hold_ok), N'(1'b1));
        chk({tag, "_result"}, res_at_done, exp);
        chk({tag, "_result_kept"}, res_after, exp);
        prev_res = exp;
    endtask

    initial begin
        logic [N-1:0] m13, mbig, a, b, m, mask, exp;
        logic         s;
        int           len;
        logic         saw_done;

        errors   = 0;
        checks   = 0;
        prev_res = '0;
        resetn   = 1'b0;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        m13      = N'(13);
        mbig     = {N{1'b1}};

        // Reset must act before any clock edge.
        #3;
        chk("rst_result", result, '0);
        chk("rst_done", N'(done), '0);
        chk("rst_busy", N'(busy), '0);

        // First start on the first rising edge after release.
        @(negedge clk);
        resetn = 1'b1;
        run_op(N'(7), N'(9), m13, 1'b0, N'(3), "add_7_9", 1'b0);
        run_op(N'(3), N'(9), m13, 1'b1, N'(7), "sub_3_9", 1'b0);
        run_op(N'(9), N'(3), m13, 1'b1, N'(6), "sub_9_3", 1'b0);
        run_op(N'(6), N'(7), m13, 1'b0, N'(0), "add_eq_m", 1'b0);
        run_op(N'(5), N'(5), m13, 1'b1, N'(0), "sub_equal", 1'b0);
        run_op(mbig - 1'b1, mbig - 1'b1, mbig, 1'b0, mbig - N'(2), "big_add", 1'b0);
        run_op('0, mbig - 1'b1, mbig, 1'b1, N'(1), "big_sub", 1'b0);

        // Starts during busy are ignored; back-to-back start at t+5 completes at t+9.
        run_op(N'(12), N'(12), m13, 1'b0, N'(11), "noisy_start", 1'b1);
        run_op(N'(2), N'(11), m13, 1'b1, N'(4), "back_to_back", 1'b0);

        // Reset in the middle of an operation.
        in_a = N'(8);
        in_b = N'(8);
        in_m = m13;
        subtract = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", N'(busy), '0);
        chk("midrst_done", N'(done), '0);
        chk("midrst_result", result, '0);
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", N'(saw_done), '0);
        prev_res = '0;
        run_op(N'(10), N'(4), m13, 1'b0, N'(1), "after_rst", 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 10000; i++) begin
            len = $urandom_range(1, N);
            mask = {N{1'b1}} >> (N - len);
            m = rnd_wide() & mask;
            m[len-1] = 1'b1;
            a = rnd_wide() % m;
            b = rnd_wide() % m;
            case ($urandom_range(0, 7))
                0: b = (a == '0) ? '0 : m - a;
                1: b = a;
                default: ;
            endcase
            s = 1'($urandom);
            exp = model(a, b, m, s);
            run_op(a, b, m, s, exp, $sformatf("rand%0d", i), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
